stable_matching_seq_ctrl: RTL and testbench
===========================================

Name: stable_matching_seq_ctrl

Overview:
- Sequential Gale-Shapley scheduler. Suitor-side preference lists are in S, reviewer-side lists are in R.
- Each cycle it selects one free suitor and issues that suitor's next proposal. The target reviewer accepts or rejects, and the held-match state updates accordingly.
- It is the clocked, area-lean counterpart to the combinational matcher. It uses the same list semantics and the same output layout: one logS-bit match entry per reviewer plus a finish flag.

Parameters:
- Kr, 4, preference-list length per reviewer (entries are suitor ids).
- Ks, 4, preference-list length per suitor (entries are reviewer ids).
- S, 4, number of suitors; S>=2.
- R, 4, number of reviewers; R>=2.
- Derived localparams:
  - logS=log2(S), logR=log2(R), logKr=log2(Kr+1).
  - CW=log2(S*Ks+2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled request; honoured only in IDLE or DONE.
- r_pref  in  R*Kr*logS  entry j of reviewer i at bits [(i*Kr+j)*logS +: logS]; j=0 is most preferred.
- s_pref  in  S*Ks*logR  entry j of suitor i at bits [(i*Ks+j)*logR +: logR]; j=0 is most preferred.
- busy  out  1  high in RUN.
- done  out  1  finish flag; high in DONE.
- match_list  out  R*logS  suitor held by reviewer i, at [i*logS +: logS]; zero where unmatched.
- matched  out  R  bit i set when reviewer i holds a suitor.
- prop_cnt  out  CW  proposals issued since the last start.

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0. Internal per-suitor next-index, free flags and per-reviewer held-rank registers are cleared.
- States and transitions:
  - IDLE, on start=1: latch r_pref/s_pref into internal registers. Clear matches and prop_cnt. Set every suitor free with next-index 0. Go to RUN.
  - RUN, each cycle:
    - Candidate = lowest-index suitor s with free[s]=1 and next[s]<Ks.
    - If there is no candidate, go to DONE. No proposal is issued that cycle.
    - Otherwise, let target t=s_pref[s][next[s]]. Increment next[s] and prop_cnt.
    - If t>=R (only possible when R is not a power of 2), the proposal is rejected.
    - Otherwise compute rk=rank of s in r_pref[t]: the first j with entry==s, or Kr if s is absent.
    - Accept iff rk<Kr and (matched[t]=0 or rk<held_rank[t]).
    - On accept: free[s]=0. The previous holder, if any, becomes free. Update match_list[t], matched[t] and held_rank[t].
  - DONE: done=1. Outputs hold. start=1 restarts exactly as from IDLE (relatch, clear).
- start in RUN is ignored. The latched lists are immune to input changes after the start edge.
- Latency: with P proposals, done rises at the edge P+1 cycles after the start-sampling edge. The worst case is P=S*Ks.
- Exhausted suitors (next=Ks) remain unmatched. They are never re-selected.
- Duplicate ids in a reviewer list: the first occurrence defines the rank. Duplicate ids in a suitor list: the repeated proposal is allowed and is evaluated normally.
- Tie in rank is impossible, because a reviewer never compares a suitor with itself.
- Reset mid-RUN aborts immediately. Outputs return to 0.

Decomposition:
- Package stable_matching_pkg:
  - log2 function.
  - State enum IDLE/RUN/DONE.
  - Slice-index helper functions for r_pref/s_pref/match_list.
- Sub-module sm_rank_lookup (combinational):
  - Inputs: one reviewer's Kr-entry list and a suitor id.
  - Outputs: rank (logKr bits) and listed flag.
- Top module holds the FSM, priority selector, and per-suitor/per-reviewer registers.

Test Plan:
All scenarios use S=R=Ks=Kr=4.
1. Suitor i list [i,...], reviewer i list [i,...], start -> 4 proposals; done 5 cycles after start; match_list r0..r3={0,1,2,3}; matched=1111; prop_cnt=4.
2. All suitors [0,1,2,3], all reviewers [0,1,2,3] -> prop_cnt=10; match_list={0,1,2,3}; done 11 cycles after start.
3. All suitors [0,1,2,3]; reviewer0 [3,2,1,0]; others [0,1,2,3] -> displacement chain; prop_cnt=10; match_list r0..r3={3,0,1,2}; matched=1111.
4. All suitors [0,0,0,0], reviewers [0,1,2,3] -> s1..s3 exhausted; prop_cnt=13; matched=0001; r0=0; other entries 0.
5. Scenario 2 with start pulsed again in cycle 3 of RUN, then rst=0 in cycle 6 -> start ignored; after rst all outputs 0 and state IDLE; a later start reproduces scenario 2 exactly.
6. Finish scenario 3, change inputs to scenario 1 and assert start in DONE -> busy next cycle, prop_cnt restarts at 0, final result equals scenario 1.

Source files
------------

// File: rtl/stable_matching_pkg.sv
// Shared types and slice helpers for the sequential stable-matching scheduler.
// Preference lists and match entries are flat packed vectors addressed via these helpers.
package stable_matching_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Ceiling log2, never below 1 so every derived field has at least one bit.
  function automatic int log2(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < x) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int r_slice(input int i, input int j, input int kr, input int logs);
    return (i * kr + j) * logs;
  endfunction

  function automatic int s_slice(input int i, input int j, input int ks, input int logr);
    return (i * ks + j) * logr;
  endfunction

  function automatic int m_slice(input int i, input int logs);
    return i * logs;
  endfunction

endpackage

// File: rtl/stable_matching_seq_ctrl_rank_lookup.sv
// Rank of one suitor id within a single reviewer's list: first matching entry wins,
// Kr with listed=0 when the id does not appear.
module sm_rank_lookup
  import stable_matching_pkg::*;
#(
  parameter int Kr    = 4,
  parameter int S     = 4,
  parameter int logS  = log2(S),
  parameter int logKr = log2(Kr + 1)
) (
  input  logic [Kr*logS-1:0] list,
  input  logic [logS-1:0]    id,
  output logic [logKr-1:0]   rank,
  output logic               listed
);

  always_comb begin
    rank   = logKr'(Kr);
    listed = 1'b0;
    // Scan from the back so the lowest matching index is the one left standing.
    for (int j = Kr - 1; j >= 0; j--) begin
      if (list[r_slice(0, j, Kr, logS) +: logS] == id) begin
        rank   = logKr'(j);
        listed = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stable_matching_seq_ctrl.sv
// Clocked Gale-Shapley scheduler: one proposal per RUN cycle from the lowest-index free
// suitor; the target reviewer keeps whichever of new proposer and current holder it ranks higher.
module stable_matching_seq_ctrl
  import stable_matching_pkg::*;
#(
  parameter int Kr = 4,
  parameter int Ks = 4,
  parameter int S  = 4,
  parameter int R  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [R*Kr*log2(S)-1:0]        r_pref,
  input  logic [S*Ks*log2(R)-1:0]        s_pref,
  output logic                           busy,
  output logic                           done,
  output logic [R*log2(S)-1:0]           match_list,
  output logic [R-1:0]                   matched,
  output logic [log2(S*Ks+2)-1:0]        prop_cnt
);

  localparam int logS  = log2(S);
  localparam int logR  = log2(R);
  localparam int logKr = log2(Kr + 1);
  localparam int CW    = log2(S * Ks + 2);
  localparam int NW    = log2(Ks + 1);

  state_t                  state_reg;
  logic [R*Kr*logS-1:0]    r_pref_reg;
  logic [S*Ks*logR-1:0]    s_pref_reg;
  logic [NW-1:0]           next_reg [S];
  logic [S-1:0]            free_reg;
  logic [logKr-1:0]        held_rank_reg [R];
  logic [R*logS-1:0]       match_list_reg;
  logic [R-1:0]            matched_reg;
  logic [CW-1:0]           prop_cnt_reg;
  logic                    busy_reg;
  logic                    done_reg;

  logic [S-1:0]            elig;
  logic                    cand_found;
  logic [logS-1:0]         cand;
  logic [NW-1:0]           cand_next;
  logic [logR-1:0]         target;
  logic                    t_ok;
  logic [logR-1:0]         t_sel;
  logic [Kr*logS-1:0]      rev_list;
  logic [logKr-1:0]        rk;
  logic                    rk_listed;
  logic                    accept;
  logic [logS-1:0]         prev_holder;

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_elig
      assign elig[gi] = free_reg[gi] && (next_reg[gi] < NW'(Ks));
    end
  endgenerate

  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    for (int i = S - 1; i >= 0; i--) begin
      if (elig[i]) begin
        cand_found = 1'b1;
        cand       = logS'(i);
      end
    end
  end

  // An exhausted suitor's next index would point past its list, so mask it when idle.
  assign cand_next = cand_found ? next_reg[cand] : '0;
  assign target    = s_pref_reg[s_slice(int'(cand), int'(cand_next), Ks, logR) +: logR];
  assign t_ok      = (int'(target) < R);
  assign t_sel     = t_ok ? target : '0;
  assign rev_list  = r_pref_reg[r_slice(int'(t_sel), 0, Kr, logS) +: Kr*logS];
  assign prev_holder = match_list_reg[m_slice(int'(t_sel), logS) +: logS];

  sm_rank_lookup #(.Kr(Kr), .S(S)) u_rank (
    .list   (rev_list),
    .id     (cand),
    .rank   (rk),
    .listed (rk_listed)
  );

  assign accept = cand_found && t_ok && rk_listed &&
                  (!matched_reg[t_sel] || (rk < held_rank_reg[t_sel]));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      r_pref_reg     <= '0;
      s_pref_reg     <= '0;
      free_reg       <= '0;
      match_list_reg <= '0;
      matched_reg    <= '0;
      prop_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      for (int i = 0; i < S; i++) next_reg[i] <= '0;
      for (int i = 0; i < R; i++) held_rank_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            r_pref_reg     <= r_pref;
            s_pref_reg     <= s_pref;
            free_reg       <= '1;
            match_list_reg <= '0;
            matched_reg    <= '0;
            prop_cnt_reg   <= '0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            state_reg      <= RUN;
            for (int i = 0; i < S; i++) next_reg[i] <= '0;
            for (int i = 0; i < R; i++) held_rank_reg[i] <= '0;
          end
        end
        RUN: begin
          if (!cand_found) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            next_reg[cand] <= next_reg[cand] + NW'(1);
            prop_cnt_reg   <= prop_cnt_reg + CW'(1);
            if (accept) begin
              // The proposer is free, so it can never be the displaced holder.
              free_reg[cand] <= 1'b0;
              if (matched_reg[t_sel]) free_reg[prev_holder] <= 1'b1;
              match_list_reg[m_slice(int'(t_sel), logS) +: logS] <= cand;
              matched_reg[t_sel]   <= 1'b1;
              held_rank_reg[t_sel] <= rk;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign match_list = match_list_reg;
  assign matched    = matched_reg;
  assign prop_cnt   = prop_cnt_reg;

endmodule

// File: tb/tb_stable_matching_seq_ctrl.sv
// Directed bench for stable_matching_seq_ctrl with S=R=Ks=Kr=4 and hand-computed results.
module tb_stable_matching_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] r_pref;
  logic [31:0] s_pref;
  logic        busy;
  logic        done;
  logic [7:0]  match_list;
  logic [3:0]  matched;
  logic [4:0]  prop_cnt;

  int n_vec = 0;
  int n_err = 0;

  stable_matching_seq_ctrl #(.Kr(4), .Ks(4), .S(4), .R(4)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .start      (start),
    .r_pref     (r_pref),
    .s_pref     (s_pref),
    .busy       (busy),
    .done       (done),
    .match_list (match_list),
    .matched    (matched),
    .prop_cnt   (prop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // List [a,b,c,d] with entry 0 in the low bits.
  function automatic logic [7:0] lst(input int a, input int b, input int c, input int d);
    return {2'(d), 2'(c), 2'(b), 2'(a)};
  endfunction

  task automatic set_scn1();
    s_pref = {lst(3,0,1,2), lst(2,3,0,1), lst(1,2,3,0), lst(0,1,2,3)};
    r_pref = {lst(3,0,1,2), lst(2,3,0,1), lst(1,2,3,0), lst(0,1,2,3)};
  endtask

  task automatic set_scn2();
    s_pref = {4{lst(0,1,2,3)}};
    r_pref = {4{lst(0,1,2,3)}};
  endtask

  task automatic set_scn3();
    s_pref = {4{lst(0,1,2,3)}};
    r_pref = {{3{lst(0,1,2,3)}}, lst(3,2,1,0)};
  endtask

  task automatic set_scn4();
    s_pref = {4{lst(0,0,0,0)}};
    r_pref = {4{lst(0,1,2,3)}};
  endtask

  // Start a run, scramble the inputs after the sampling edge, return edges until done.
  task automatic do_start(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    s_pref = ~s_pref;
    r_pref = ~r_pref;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; r_pref = '0; s_pref = '0;
    #2;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (match_list !== 8'h00) begin n_err++; $display("FAIL reset_match_list got=%h exp=00", match_list); end
    n_vec++; if (matched !== 4'h0) begin n_err++; $display("FAIL reset_matched got=%b exp=0000", matched); end
    n_vec++; if (prop_cnt !== 5'd0) begin n_err++; $display("FAIL reset_prop_cnt got=%0d exp=0", prop_cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset: busy=%b done=%b ml=%h matched=%b pc=%0d", busy, done, match_list, matched, prop_cnt);
  endtask

  task automatic test_identity();
    int lat;
    set_scn1();
    do_start(lat);
    $display("scn1 identity: lat=%0d pc=%0d ml=%h matched=%b", lat, prop_cnt, match_list, matched);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL scn1_latency got=%0d exp=5", lat); end
    n_vec++; if (prop_cnt !== 5'd4) begin n_err++; $display("FAIL scn1_prop_cnt got=%0d exp=4", prop_cnt); end
    n_vec++; if (match_list !== 8'he4) begin n_err++; $display("FAIL scn1_match_list got=%h exp=e4", match_list); end
    n_vec++; if (matched !== 4'hf) begin n_err++; $display("FAIL scn1_matched got=%b exp=1111", matched); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL scn1_busy got=%b exp=0", busy); end
  endtask

  task automatic test_common_pref();
    int lat;
    set_scn2();
    do_start(lat);
    $display("scn2 common: lat=%0d pc=%0d ml=%h matched=%b", lat, prop_cnt, match_list, matched);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL scn2_latency got=%0d exp=11", lat); end
    n_vec++; if (prop_cnt !== 5'd10) begin n_err++; $display("FAIL scn2_prop_cnt got=%0d exp=10", prop_cnt); end
    n_vec++; if (match_list !== 8'he4) begin n_err++; $display("FAIL scn2_match_list got=%h exp=e4", match_list); end
    n_vec++; if (matched !== 4'hf) begin n_err++; $display("FAIL scn2_matched got=%b exp=1111", matched); end
  endtask

  task automatic test_displacement();
    int lat;
    set_scn3();
    do_start(lat);
    $display("scn3 displacement: lat=%0d pc=%0d ml=%h matched=%b", lat, prop_cnt, match_list, matched);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL scn3_latency got=%0d exp=11", lat); end
    n_vec++; if (prop_cnt !== 5'd10) begin n_err++; $display("FAIL scn3_prop_cnt got=%0d exp=10", prop_cnt); end
    n_vec++; if (match_list !== 8'h93) begin n_err++; $display("FAIL scn3_match_list got=%h exp=93", match_list); end
    n_vec++; if (matched !== 4'hf) begin n_err++; $display("FAIL scn3_matched got=%b exp=1111", matched); end
  endtask

  task automatic test_exhaustion();
    int lat;
    set_scn4();
    do_start(lat);
    $display("scn4 exhaustion: lat=%0d pc=%0d ml=%h matched=%b", lat, prop_cnt, match_list, matched);
    n_vec++; if (lat !== 14) begin n_err++; $display("FAIL scn4_latency got=%0d exp=14", lat); end
    n_vec++; if (prop_cnt !== 5'd13) begin n_err++; $display("FAIL scn4_prop_cnt got=%0d exp=13", prop_cnt); end
    n_vec++; if (match_list !== 8'h00) begin n_err++; $display("FAIL scn4_match_list got=%h exp=00", match_list); end
    n_vec++; if (matched !== 4'b0001) begin n_err++; $display("FAIL scn4_matched got=%b exp=0001", matched); end
  endtask

  task automatic test_ignore_start_and_abort();
    int lat;
    set_scn2();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    $display("scn5 start in RUN: busy=%b done=%b pc=%0d", busy, done, prop_cnt);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL scn5_busy_kept got=%b exp=1", busy); end
    n_vec++; if (prop_cnt !== 5'd4) begin n_err++; $display("FAIL scn5_no_restart got=%0d exp=4", prop_cnt); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("scn5 abort: busy=%b done=%b ml=%h matched=%b pc=%0d", busy, done, match_list, matched, prop_cnt);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL scn5_abort_busy got=%b exp=0", busy); end
    n_vec++; if (prop_cnt !== 5'd0) begin n_err++; $display("FAIL scn5_abort_prop_cnt got=%0d exp=0", prop_cnt); end
    n_vec++; if (matched !== 4'h0) begin n_err++; $display("FAIL scn5_abort_matched got=%b exp=0000", matched); end
    n_vec++; if (match_list !== 8'h00) begin n_err++; $display("FAIL scn5_abort_match_list got=%h exp=00", match_list); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL scn5_stays_idle got=%b exp=00", {busy, done}); end
    set_scn2();
    do_start(lat);
    $display("scn5 rerun: lat=%0d pc=%0d ml=%h matched=%b", lat, prop_cnt, match_list, matched);
    n_vec++; if (lat !== 11) begin n_err++; $display("FAIL scn5_rerun_latency got=%0d exp=11", lat); end
    n_vec++; if (prop_cnt !== 5'd10) begin n_err++; $display("FAIL scn5_rerun_prop_cnt got=%0d exp=10", prop_cnt); end
    n_vec++; if (match_list !== 8'he4) begin n_err++; $display("FAIL scn5_rerun_match_list got=%h exp=e4", match_list); end
  endtask

  task automatic test_restart_from_done();
    int lat;
    set_scn3();
    do_start(lat);
    n_vec++; if (match_list !== 8'h93) begin n_err++; $display("FAIL scn6_first_match_list got=%h exp=93", match_list); end
    set_scn1();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    $display("scn6 restart: busy=%b done=%b pc=%0d matched=%b", busy, done, prop_cnt, matched);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL scn6_busy got=%b exp=1", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL scn6_done_cleared got=%b exp=0", done); end
    n_vec++; if (prop_cnt !== 5'd0) begin n_err++; $display("FAIL scn6_prop_cnt_cleared got=%0d exp=0", prop_cnt); end
    n_vec++; if (matched !== 4'h0) begin n_err++; $display("FAIL scn6_matched_cleared got=%b exp=0000", matched); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("scn6 result: lat=%0d pc=%0d ml=%h matched=%b", lat, prop_cnt, match_list, matched);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL scn6_latency got=%0d exp=5", lat); end
    n_vec++; if (prop_cnt !== 5'd4) begin n_err++; $display("FAIL scn6_prop_cnt got=%0d exp=4", prop_cnt); end
    n_vec++; if (match_list !== 8'he4) begin n_err++; $display("FAIL scn6_match_list got=%h exp=e4", match_list); end
    n_vec++; if (matched !== 4'hf) begin n_err++; $display("FAIL scn6_matched got=%b exp=1111", matched); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_common_pref();
    test_displacement();
    test_exhaustion();
    test_ignore_start_and_abort();
    test_restart_from_done();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
